// File: rtl/matrix_operand_loader_if.sv
// matrix_operand_loader_if: element stream in, operand words to the multiplier, result back, and
// result stream out. The slave modport is the loader's view; master is the environment's view.
// Optional feature macro: B_REUSE_EN adds reuse_b.
interface matrix_operand_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [7:0]  A_row0;
  logic [7:0]  A_row1;
  logic [7:0]  B_col0;
  logic [7:0]  B_col1;
  logic [7:0]  C_row0;
  logic [7:0]  C_row1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
`ifdef B_REUSE_EN
  logic        reuse_b;
`endif

  modport master (
    output in_valid, in_data, C_row0, C_row1, out_ready,
`ifdef B_REUSE_EN
    output reuse_b,
`endif
    input  in_ready, A_row0, A_row1, B_col0, B_col1, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, C_row0, C_row1, out_ready,
`ifdef B_REUSE_EN
    input  reuse_b,
`endif
    output in_ready, A_row0, A_row1, B_col0, B_col1, out_valid, out_data, busy
  );
endinterface

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: packs a serial stream of 4-bit elements into the four 8-bit operand
// words of a 2x2 nibble multiplier, holds them for MUL_LATENCY cycles, captures {C_row1, C_row0}
// and returns it over a valid/ready handshake. One operation in flight at a time.
// Optional feature macro: B_REUSE_EN (reuse_b at slot 3 keeps the previous B words).
module matrix_operand_loader #(
  parameter int unsigned MUL_LATENCY = 1  // 1..7
) (
  input logic                    clk,
  input logic                    rst_n,
  matrix_operand_loader_if.slave bus
);
  typedef enum logic [1:0] {StLoad, StWait, StOut} state_e;

  localparam logic [2:0] LatCnt = 3'(MUL_LATENCY);

  state_e      r_state, w_state_next;
  logic [2:0]  r_elem_cnt, w_elem_cnt_next;
  logic [2:0]  r_wait_cnt, w_wait_cnt_next;
  logic [31:0] r_ops;        // {B_col1, B_col0, A_row1, A_row0}; slot k sits at bits 4k+3:4k
  logic [15:0] r_out_data;
  logic        r_rst_done;   // keeps in_ready low until the first clock after reset
  logic        w_in_ready;
  logic        w_in_fire;
  logic        w_last_elem;
  logic        w_capture;

  assign w_in_ready = (r_state == StLoad) && r_rst_done;
  assign w_in_fire  = w_in_ready && bus.in_valid;

`ifdef B_REUSE_EN
  assign w_last_elem = (r_elem_cnt == 3'd7) || ((r_elem_cnt == 3'd3) && bus.reuse_b);
`else
  assign w_last_elem = (r_elem_cnt == 3'd7);
`endif

  // Next-state, element/wait counters and result-capture strobe.
  always_comb begin
    w_state_next    = r_state;
    w_elem_cnt_next = r_elem_cnt;
    w_wait_cnt_next = r_wait_cnt;
    w_capture       = 1'b0;
    case (r_state)
      StLoad: begin
        if (w_in_fire) begin
          if (w_last_elem) begin
            w_elem_cnt_next = 3'd0;
            w_wait_cnt_next = 3'd0;
            w_state_next    = StWait;
          end else begin
            w_elem_cnt_next = r_elem_cnt + 3'd1;
          end
        end
      end
      StWait: begin
        if (r_wait_cnt == LatCnt) begin
          w_capture       = 1'b1;
          w_wait_cnt_next = 3'd0;
          w_state_next    = StOut;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 3'd1;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          w_state_next = StLoad;
        end
      end
      default: w_state_next = StLoad;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StLoad;
      r_elem_cnt <= 3'd0;
      r_wait_cnt <= 3'd0;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_elem_cnt <= w_elem_cnt_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_rst_done <= 1'b1;
    end
  end

  // Operand slots written one element at a time; result captured once per operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ops      <= 32'h0;
      r_out_data <= 16'h0;
    end else begin
      if (w_in_fire) begin
        r_ops[{r_elem_cnt, 2'b00} +: 4] <= bus.in_data;
      end
      if (w_capture) begin
        r_out_data <= {bus.C_row1, bus.C_row0};
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.A_row0    = r_ops[7:0];
  assign bus.A_row1    = r_ops[15:8];
  assign bus.B_col0    = r_ops[23:16];
  assign bus.B_col1    = r_ops[31:24];
  assign bus.out_valid = (r_state == StOut);
  assign bus.out_data  = r_out_data;
  assign bus.busy      = !((r_state == StLoad) && (r_elem_cnt == 3'd0));

endmodule
